scaled_line_fetcher: RTL and testbench
======================================

SCALED_LINE_FETCHER -- requirements
Module: scaled_line_fetcher

Interface
REQ-001 SHALL have parameter PIX_W, default 4: bits per pixel.
REQ-002 SHALL have parameter SRC_W, default 64: source pixels per row; divisible by PPW.
REQ-003 SHALL have parameter SRC_H, default 48: source rows per frame.
REQ-004 SHALL have parameter SCALE, default 10: horizontal and vertical replication factor, ≥2.
REQ-005 SHALL have parameter PPW, default 8: pixels per memory word.
REQ-006 SHALL have parameter ADDR_W, default 9: memory word address width, ≥ clog2(SRC_H*SRC_W/PPW).
REQ-007 SHALL have port clk_25, input, 1: pixel clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port disp_active, input, 1: display in visible region.
REQ-010 SHALL have port line_end, input, 1: one-cycle pulse after each visible line.
REQ-011 SHALL have port frame_end, input, 1: one-cycle pulse at frame end, before the first visible line.
REQ-012 SHALL have port mem_req, output, 1: word read request.
REQ-013 SHALL have port mem_addr, output, ADDR_W: word address.
REQ-014 SHALL have port mem_ack, input, 1: request accepted; mem_rdata valid this cycle.
REQ-015 SHALL have port mem_rdata, input, PIX_W*PPW: packed pixels; pixel k at bits [k*PIX_W +: PIX_W].
REQ-016 SHALL have port pixel_out, output, PIX_W: scaled pixel.
REQ-017 SHALL have port fetch_busy, output, 1: fetch FSM not IDLE.
REQ-018 SHALL have port underrun, output, 1: sticky; a row was displayed before its fetch completed.

Function
REQ-019 SHALL hold two SRC_W x PIX_W line buffers (ping-pong); disp_sel selects the display buffer, the other is the fetch target.
REQ-020 SHALL count h_cnt 0..SCALE-1 while disp_active; at SCALE-1 wrap to 0 and increment h_pix (0..SRC_W-1); both held 0 while disp_active low.
REQ-021 SHALL register pixel_out = buffer[disp_sel][h_pix] one cycle after disp_active sampled high; pixel_out = 0 the cycle after disp_active sampled low.
REQ-022 SHALL increment v_cnt (0..SCALE-1) on line_end; at SCALE-1 wrap to 0, advance v_pix (wrap SRC_H-1 -> 0), toggle disp_sel (a "swap").
REQ-023 SHALL implement fetch FSM states IDLE, REQ, STORE.
REQ-024 IDLE -> REQ on a fetch start; REQ holds mem_req=1 with stable mem_addr until mem_ack sampled 1 -> STORE; STORE writes PPW pixels at columns word*PPW..word*PPW+PPW-1, mem_req=0, then -> REQ for next word, or -> IDLE after word SRC_W/PPW-1.
REQ-025 SHALL drive mem_addr = row*(SRC_W/PPW) + word; mem_req=0 and mem_addr=0 outside REQ.
REQ-026 On frame_end: v_cnt=0, v_pix=0, disp_sel=0, underrun cleared; fetch row 0 into buffer 0, then immediately row 1 into buffer 1 (if SRC_H>1).
REQ-027 On each swap to row r≥1: fetch row r+1 into the freed buffer if r+1<SRC_H; no fetch after swap to last row.
REQ-028 SHALL set underrun on a swap while the fetch of the incoming row is incomplete; swap still occurs; fetch continues.
REQ-029 frame_end during REQ: outstanding handshake completes, data discarded, then REQ-026 sequence starts; frame_end in IDLE/STORE restarts immediately.
REQ-030 frame_end and line_end in the same cycle: frame_end wins, line_end ignored.
REQ-031 A fetch start while a fetch is active SHALL be queued (depth 1) and begin on return to IDLE.

Reset
REQ-032 rst_n low SHALL immediately force: FSM IDLE, mem_req=0, mem_addr=0, pixel_out=0, fetch_busy=0, underrun=0, all counters 0, disp_sel=0; buffer contents undefined.
REQ-033 After reset release no fetch SHALL occur until the first frame_end.

Verification
REQ-034 Reset then frame_end, mem_ack=1 every REQ cycle -> addresses 0..7 (row 0) then 8..15 (row 1), 2 cycles/word, fetch_busy low after 32 cycles.
REQ-035 Row 0 word k = {8{k[3:0]}}; first visible line -> pixel_out = k for 80 consecutive cycles per word k, 1-cycle latency.
REQ-036 Tenth line_end of row 0 -> swap; row-1 data displayed; addresses 16..23 fetched; underrun stays 0.
REQ-037 mem_ack withheld 2000 cycles during row-2 fetch -> underrun=1 at swap to row 2; mem_req/mem_addr stable throughout; underrun clears at next frame_end.
REQ-038 frame_end while REQ pending -> mem_req stays high until ack, then next request addr 0.
REQ-039 rst_n asserted mid-fetch -> mem_req=0 same cycle; no requests until frame_end.

Source files
------------

// File: rtl/scaled_line_fetcher.sv
// Fetches source rows from word-wide memory into ping-pong line buffers and
// replays each pixel SCALE times horizontally and each row SCALE times vertically.
`timescale 1ns/1ps
module scaled_line_fetcher #(
    parameter int PIX_W  = 4,
    parameter int SRC_W  = 64,
    parameter int SRC_H  = 48,
    parameter int SCALE  = 10,
    parameter int PPW    = 8,
    parameter int ADDR_W = 9
) (
    input  logic                   clk_25,
    input  logic                   rst_n,
    input  logic                   disp_active,
    input  logic                   line_end,
    input  logic                   frame_end,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_ack,
    input  logic [PIX_W*PPW-1:0]   mem_rdata,
    output logic [PIX_W-1:0]       pixel_out,
    output logic                   fetch_busy,
    output logic                   underrun
);
    localparam int WPR    = SRC_W / PPW;
    localparam int WORD_W = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int ROW_W  = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam int HC_W   = $clog2(SCALE);

    typedef enum logic [1:0] {IDLE, REQ, STORE} fetch_state_t;

    fetch_state_t            state_q, state_d;
    logic [WORD_W-1:0]       word_q, word_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic                    fbuf_q, fbuf_d;
    logic                    pend_q, pend_d;
    logic [ROW_W-1:0]        pend_row_q, pend_row_d;
    logic                    pend_buf_q, pend_buf_d;
    logic                    restart_q, restart_d;
    logic [1:0]              ready_q, ready_d;
    logic [PIX_W*PPW-1:0]    rdata_q, rdata_d;
    logic [HC_W-1:0]         h_cnt_q, h_cnt_d;
    logic [LANE_W-1:0]       h_lane_q, h_lane_d;
    logic [WORD_W-1:0]       h_word_q, h_word_d;
    logic [HC_W-1:0]         v_cnt_q, v_cnt_d;
    logic [ROW_W-1:0]        v_pix_q, v_pix_d;
    logic                    disp_sel_q, disp_sel_d;
    logic                    underrun_q, underrun_d;
    logic [PIX_W-1:0]        pixel_q, pixel_d;

    logic                    line_ok, swap, start_v, store_last, in_ready, launch, mem_we;
    logic [ROW_W-1:0]        v_pix_inc, start_row;
    logic [PIX_W-1:0]        rd_lane [PPW];

    assign line_ok    = line_end && !frame_end;
    assign swap       = line_ok && (v_cnt_q == HC_W'(SCALE - 1));
    assign v_pix_inc  = (v_pix_q == ROW_W'(SRC_H - 1)) ? '0 : v_pix_q + ROW_W'(1);
    assign start_row  = v_pix_inc + ROW_W'(1);
    assign start_v    = swap && (v_pix_inc != '0) && (int'(v_pix_inc) + 1 < SRC_H);
    assign store_last = (state_q == STORE) && (word_q == WORD_W'(WPR - 1));
    // A row whose last word is being stored right now counts as complete.
    assign in_ready   = ready_q[~disp_sel_q] || (store_last && (fbuf_q == ~disp_sel_q));
    assign mem_we     = (state_q == STORE) && !frame_end;

    assign mem_req    = (state_q == REQ);
    assign mem_addr   = (state_q == REQ) ?
                        ADDR_W'(row_q) * ADDR_W'(WPR) + ADDR_W'(word_q) : '0;
    assign fetch_busy = (state_q != IDLE);
    assign underrun   = underrun_q;
    assign pixel_out  = pixel_q;

    generate
        for (genvar gi = 0; gi < PPW; gi++) begin : g_lane
            logic [PIX_W-1:0] lane_mem [2][WPR];
            always_ff @(posedge clk_25) begin
                if (mem_we) lane_mem[fbuf_q][word_q] <= rdata_q[gi*PIX_W +: PIX_W];
            end
            assign rd_lane[gi] = lane_mem[disp_sel_q][h_word_q];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        row_d      = row_q;
        fbuf_d     = fbuf_q;
        pend_d     = pend_q;
        pend_row_d = pend_row_q;
        pend_buf_d = pend_buf_q;
        restart_d  = restart_q;
        rdata_d    = rdata_q;
        ready_d    = ready_q;
        launch     = 1'b0;
        if (frame_end) begin
            pend_d     = (SRC_H > 1);
            pend_row_d = ROW_W'(1);
            pend_buf_d = 1'b1;
            ready_d    = '0;
            // An unanswered request must finish its handshake before restarting.
            if (state_q == REQ && !mem_ack) begin
                restart_d = 1'b1;
            end else begin
                state_d   = REQ;
                word_d    = '0;
                row_d     = '0;
                fbuf_d    = 1'b0;
                restart_d = 1'b0;
            end
        end else begin
            if (start_v) begin
                pend_d     = 1'b1;
                pend_row_d = start_row;
                pend_buf_d = disp_sel_q;
            end
            case (state_q)
                IDLE: launch = 1'b1;
                REQ: begin
                    if (mem_ack) begin
                        if (restart_q) begin
                            restart_d = 1'b0;
                            word_d    = '0;
                            row_d     = '0;
                            fbuf_d    = 1'b0;
                        end else begin
                            rdata_d = mem_rdata;
                            state_d = STORE;
                        end
                    end
                end
                STORE: begin
                    if (store_last) begin
                        ready_d[fbuf_q] = 1'b1;
                        state_d         = IDLE;
                        launch          = 1'b1;
                    end else begin
                        word_d  = word_q + WORD_W'(1);
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (launch) begin
                if (pend_q) begin
                    state_d = REQ;
                    word_d  = '0;
                    row_d   = pend_row_q;
                    fbuf_d  = pend_buf_q;
                    pend_d  = start_v;
                end else if (start_v) begin
                    state_d = REQ;
                    word_d  = '0;
                    row_d   = start_row;
                    fbuf_d  = disp_sel_q;
                    pend_d  = 1'b0;
                end
            end
            if (swap) ready_d[disp_sel_q] = 1'b0;
        end
    end

    always_comb begin
        h_cnt_d    = '0;
        h_lane_d   = '0;
        h_word_d   = '0;
        v_cnt_d    = v_cnt_q;
        v_pix_d    = v_pix_q;
        disp_sel_d = disp_sel_q;
        underrun_d = underrun_q;
        pixel_d    = disp_active ? rd_lane[h_lane_q] : '0;
        if (disp_active) begin
            h_cnt_d  = h_cnt_q + HC_W'(1);
            h_lane_d = h_lane_q;
            h_word_d = h_word_q;
            if (h_cnt_q == HC_W'(SCALE - 1)) begin
                h_cnt_d = '0;
                if (h_lane_q == LANE_W'(PPW - 1)) begin
                    h_lane_d = '0;
                    h_word_d = (h_word_q == WORD_W'(WPR - 1)) ? '0 : h_word_q + WORD_W'(1);
                end else begin
                    h_lane_d = h_lane_q + LANE_W'(1);
                end
            end
        end
        if (frame_end) begin
            v_cnt_d    = '0;
            v_pix_d    = '0;
            disp_sel_d = 1'b0;
            underrun_d = 1'b0;
        end else if (swap) begin
            v_cnt_d    = '0;
            v_pix_d    = v_pix_inc;
            disp_sel_d = ~disp_sel_q;
            if (!in_ready) underrun_d = 1'b1;
        end else if (line_ok) begin
            v_cnt_d = v_cnt_q + HC_W'(1);
        end
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_q     <= '0;
            row_q      <= '0;
            fbuf_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_row_q <= '0;
            pend_buf_q <= 1'b0;
            restart_q  <= 1'b0;
            ready_q    <= '0;
            rdata_q    <= '0;
            h_cnt_q    <= '0;
            h_lane_q   <= '0;
            h_word_q   <= '0;
            v_cnt_q    <= '0;
            v_pix_q    <= '0;
            disp_sel_q <= 1'b0;
            underrun_q <= 1'b0;
            pixel_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            row_q      <= row_d;
            fbuf_q     <= fbuf_d;
            pend_q     <= pend_d;
            pend_row_q <= pend_row_d;
            pend_buf_q <= pend_buf_d;
            restart_q  <= restart_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            h_cnt_q    <= h_cnt_d;
            h_lane_q   <= h_lane_d;
            h_word_q   <= h_word_d;
            v_cnt_q    <= v_cnt_d;
            v_pix_q    <= v_pix_d;
            disp_sel_q <= disp_sel_d;
            underrun_q <= underrun_d;
            pixel_q    <= pixel_d;
        end
    end
endmodule

// File: tb/tb_scaled_line_fetcher.sv
// Directed frame/line sequences against a memory responder and a row/column
// reference model of what each scaled pixel and fetched address should be.
`timescale 1ns/1ps
module tb_scaled_line_fetcher;
    localparam int PIX_W  = 4;
    localparam int SRC_W  = 64;
    localparam int SRC_H  = 48;
    localparam int SCALE  = 10;
    localparam int PPW    = 8;
    localparam int ADDR_W = 9;
    localparam int WPR    = SRC_W / PPW;
    localparam int NWORDS = SRC_H * WPR;

    logic                 clk_25;
    logic                 rst_n;
    logic                 disp_active;
    logic                 line_end;
    logic                 frame_end;
    logic                 mem_req;
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_ack;
    logic [PIX_W*PPW-1:0] mem_rdata;
    logic [PIX_W-1:0]     pixel_out;
    logic                 fetch_busy;
    logic                 underrun;

    int vectors;
    int miscompares;
    int ack_mode;               // 0 = withhold, 1 = always, 2 = random
    int addr_log[$];
    logic [31:0] mem_model [NWORDS];

    scaled_line_fetcher #(
        .PIX_W(PIX_W), .SRC_W(SRC_W), .SRC_H(SRC_H),
        .SCALE(SCALE), .PPW(PPW), .ADDR_W(ADDR_W)
    ) dut (
        .clk_25(clk_25), .rst_n(rst_n), .disp_active(disp_active),
        .line_end(line_end), .frame_end(frame_end), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pixel_out(pixel_out), .fetch_busy(fetch_busy), .underrun(underrun)
    );

    initial clk_25 = 1'b0;
    always #20 clk_25 = ~clk_25;

    // Memory: answers requests at the falling edge, logs every accepted address.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk_25);
            if (mem_req === 1'b1 && (ack_mode == 1 || (ack_mode == 2 && $urandom_range(0, 2) == 0))) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_model[int'(mem_addr)];
                addr_log.push_back(int'(mem_addr));
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_25);
    endtask

    function automatic logic [PIX_W-1:0] exp_pix(input int row, input int col);
        logic [31:0] w;
        w = mem_model[row * WPR + col / PPW];
        return w[(col % PPW) * PIX_W +: PIX_W];
    endfunction

    task automatic pulse_line();
        line_end = 1'b1;
        tick();
        line_end = 1'b0;
        tick();
    endtask

    task automatic pulse_frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int cyc);
        cyc = 0;
        while (fetch_busy === 1'b1 && cyc < 5000) begin
            tick();
            cyc++;
        end
        check({tag, "_idle"}, fetch_busy, 1'b0);
    endtask

    task automatic expect_addrs(input string tag, input int first, input int n);
        check({tag, "_count"}, 64'(addr_log.size()), 64'(n));
        for (int i = 0; i < n && i < addr_log.size(); i++)
            check(tag, 64'(addr_log[i]), 64'(first + i));
    endtask

    // One visible line of the given source row, then the line_end pulse.
    task automatic show_line(input string tag, input int row);
        int bad;
        bad = 0;
        disp_active = 1'b1;
        for (int j = 0; j < SRC_W * SCALE; j++) begin
            tick();
            if (pixel_out !== exp_pix(row, j / SCALE)) bad++;
        end
        disp_active = 1'b0;
        check({tag, "_pixels_bad"}, 64'(bad), 64'(0));
        tick();
        check({tag, "_blank"}, pixel_out, 4'h0);
        pulse_line();
    endtask

    initial begin
        int cyc;
        int cnt;
        logic [3:0] k;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        disp_active = 1'b0;
        line_end = 1'b0;
        frame_end = 1'b0;
        ack_mode = 1;
        for (int a = 0; a < NWORDS; a++) begin
            k = a[3:0];
            mem_model[a] = (a < WPR) ? {8{k}} : $urandom;
        end

        tick(3);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_pixel_out", pixel_out, '0);
        check("rst_fetch_busy", fetch_busy, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin tick(); if (mem_req !== 1'b0) cnt++; end
        check("no_req_before_frame", 64'(cnt), 64'(0));

        // Frame A: initial double-row fetch, full row-0 display, normal swaps.
        addr_log.delete();
        pulse_frame();
        wait_idle("frameA_fetch", cyc);
        check("frameA_fetch_cycles", 64'(cyc), 64'(32));
        expect_addrs("frameA_rows01", 0, 2 * WPR);
        check("frameA_idle_req", mem_req, 1'b0);
        check("frameA_idle_addr", mem_addr, '0);
        addr_log.delete();
        for (int l = 0; l < SCALE; l++) show_line("row0_line", 0);
        wait_idle("swap_row1", cyc);
        expect_addrs("swap_row1_fetch", 2 * WPR, WPR);
        check("swap_row1_underrun", underrun, 1'b0);
        show_line("row1_line", 1);
        addr_log.delete();
        for (int l = 1; l < SCALE; l++) pulse_line();
        wait_idle("swap_row2", cyc);
        expect_addrs("swap_row2_fetch", 3 * WPR, WPR);
        check("swap_row2_underrun", underrun, 1'b0);
        show_line("row2_line", 2);

        // Frame B: random ack latency, then a withheld ack forces an underrun.
        ack_mode = 2;
        addr_log.delete();
        pulse_frame();
        wait_idle("frameB_fetch", cyc);
        expect_addrs("frameB_rows01", 0, 2 * WPR);
        show_line("frameB_row0", 0);
        ack_mode = 0;
        for (int l = 1; l < SCALE; l++) pulse_line();
        check("frameB_row1_underrun", underrun, 1'b0);
        check("stall_req", mem_req, 1'b1);
        check("stall_addr", mem_addr, 9'd16);
        cnt = 0;
        repeat (2000) begin
            tick();
            if (mem_req !== 1'b1 || mem_addr !== 9'd16) cnt++;
        end
        check("stall_stable_cycles_bad", 64'(cnt), 64'(0));
        for (int l = 0; l < SCALE; l++) pulse_line();
        check("underrun_set", underrun, 1'b1);
        check("underrun_req_held", mem_req, 1'b1);
        check("underrun_addr_held", mem_addr, 9'd16);
        ack_mode = 1;
        addr_log.delete();
        wait_idle("after_stall", cyc);
        expect_addrs("after_stall_rows23", 2 * WPR, 2 * WPR);
        check("underrun_sticky", underrun, 1'b1);
        show_line("late_row2", 2);
        pulse_frame();
        check("underrun_cleared", underrun, 1'b0);
        wait_idle("frameC_fetch", cyc);

        // frame_end while a request is outstanding.
        ack_mode = 0;
        for (int l = 0; l < SCALE; l++) pulse_line();
        check("pending_req", mem_req, 1'b1);
        check("pending_addr", mem_addr, 9'd16);
        addr_log.delete();
        pulse_frame();
        tick(3);
        check("restart_req_held", mem_req, 1'b1);
        check("restart_addr_held", mem_addr, 9'd16);
        ack_mode = 1;
        wait_idle("restart", cyc);
        check("restart_first_ack", 64'(addr_log.size() > 0 ? addr_log[0] : -1), 64'(16));
        if (addr_log.size() > 0) void'(addr_log.pop_front());
        expect_addrs("restart_rows01", 0, 2 * WPR);
        show_line("restart_row0", 0);

        // frame_end and line_end together: the line_end must not count.
        addr_log.delete();
        frame_end = 1'b1;
        line_end = 1'b1;
        tick();
        frame_end = 1'b0;
        line_end = 1'b0;
        wait_idle("both_fetch", cyc);
        for (int l = 1; l < SCALE; l++) pulse_line();
        tick(4);
        expect_addrs("both_no_early_swap", 0, 2 * WPR);
        addr_log.delete();
        pulse_line();
        wait_idle("both_swap", cyc);
        expect_addrs("both_swap_fetch", 2 * WPR, WPR);

        // Reset in the middle of a fetch.
        ack_mode = 0;
        pulse_frame();
        tick(3);
        check("midfetch_req", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_async_req", mem_req, 1'b0);
        check("rst_async_addr", mem_addr, '0);
        check("rst_async_busy", fetch_busy, 1'b0);
        tick(2);
        rst_n = 1'b1;
        ack_mode = 1;
        addr_log.delete();
        cnt = 0;
        repeat (20) begin tick(); if (mem_req !== 1'b0) cnt++; end
        check("no_req_after_reset", 64'(cnt), 64'(0));
        check("no_ack_after_reset", 64'(addr_log.size()), 64'(0));
        pulse_frame();
        wait_idle("final_fetch", cyc);
        check("final_fetch_cycles", 64'(cyc), 64'(32));
        expect_addrs("final_rows01", 0, 2 * WPR);
        show_line("final_row0", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
